// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared widths, default depth and feeder state encoding
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int UART_BYTE_W        = 8;
   localparam int DEFAULT_DEPTH_LOG2 = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACT  = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_WAIT_CLR  = 2'd3
   } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo : circular byte FIFO with occupancy count and overflow pulse
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
)(
   input  logic                   i_Clock,
   input  logic                   i_Reset,
   input  logic                   i_Wr_En,
   input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
   input  logic                   i_Rd_En,
   output logic [UART_BYTE_W-1:0] o_Rd_Byte,
   output logic                   o_Full,
   output logic                   o_Empty,
   output logic [DEPTH_LOG2:0]    o_Count,
   output logic                   o_Overflow
);

   localparam logic [DEPTH_LOG2:0] c_FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [UART_BYTE_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
   logic [DEPTH_LOG2-1:0]  r_wr_ptr;
   logic [DEPTH_LOG2-1:0]  r_rd_ptr;
   logic [DEPTH_LOG2:0]    r_count;
   logic                   r_overflow;
   logic                   w_wr_ok;
   logic                   w_rd_ok;

   assign o_Full     = (r_count == c_FULL_COUNT);
   assign o_Empty    = (r_count == '0);
   assign o_Count    = r_count;
   assign o_Overflow = r_overflow;
   assign o_Rd_Byte  = r_mem[r_rd_ptr];

   // Full is judged on the pre-edge count, so a same-edge pop cannot rescue a write
   assign w_wr_ok = i_Wr_En && !o_Full;
   assign w_rd_ok = i_Rd_En && !o_Empty;

   always_ff @(posedge i_Clock) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= i_Wr_Byte;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_overflow <= i_Wr_En && o_Full;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder : queues CPU bytes and hands them to the UART transmitter
// Rev 1.0        : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
)(
   input  logic                   i_Clock,
   input  logic                   i_Reset,
   input  logic                   i_Wr_En,
   input  logic [UART_BYTE_W-1:0] i_Wr_Byte,
   output logic                   o_Full,
   output logic                   o_Empty,
   output logic [DEPTH_LOG2:0]    o_Count,
   output logic                   o_Overflow,
   output logic                   o_Tx_DV,
   output logic [UART_BYTE_W-1:0] o_Tx_Byte,
   input  logic                   i_Tx_Active,
   input  logic                   i_Tx_Done,
   output logic                   o_Busy
);

   feeder_state_e          r_state;
   logic                   r_tx_dv;
   logic [UART_BYTE_W-1:0] r_tx_byte;
   logic                   w_pop;
   logic [UART_BYTE_W-1:0] w_rd_byte;

   // A lingering Done from the previous byte must not launch the next one
   assign w_pop = (r_state == ST_IDLE) && !o_Empty && !i_Tx_Done;

   uart_sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .i_Clock    (i_Clock),
      .i_Reset    (i_Reset),
      .i_Wr_En    (i_Wr_En),
      .i_Wr_Byte  (i_Wr_Byte),
      .i_Rd_En    (w_pop),
      .o_Rd_Byte  (w_rd_byte),
      .o_Full     (o_Full),
      .o_Empty    (o_Empty),
      .o_Count    (o_Count),
      .o_Overflow (o_Overflow)
   );

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_state   <= ST_IDLE;
         r_tx_dv   <= 1'b0;
         r_tx_byte <= '0;
      end else begin
         r_tx_dv <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_tx_dv   <= 1'b1;
                  r_tx_byte <= w_rd_byte;
                  r_state   <= ST_WAIT_ACT;
               end
            end
            ST_WAIT_ACT: begin
               if (i_Tx_Active) begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               if (i_Tx_Done) begin
                  r_state <= ST_WAIT_CLR;
               end
            end
            ST_WAIT_CLR: begin
               if (!i_Tx_Done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_Tx_DV   = r_tx_dv;
   assign o_Tx_Byte = r_tx_byte;
   assign o_Busy    = !o_Empty || (r_state != ST_IDLE);

endmodule

`default_nettype wire
